// File: rtl/r_div_seq_if.sv
// Request/response bundle for the r_div_seq iterative divider.
// Latency: wires only, no storage.
// Backpressure: valid/ready on the request side and on the result side.
//
// Signal names carry the divider's port names so the waveform reads the
// same from either end. The master modport is the issuing pipeline (or a
// bench), and the slave modport is the divider itself.
interface r_div_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic             signed_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             flush_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [WIDTH-1:0] quotient_o;
   logic [WIDTH-1:0] remainder_o;
   logic             div_zero_o;

   modport master (
      output in_valid_i, signed_i, dividend_i, divisor_i, flush_i, out_ready_i,
      input  in_ready_o, out_valid_o, quotient_o, remainder_o, div_zero_o
   );

   modport slave (
      input  in_valid_i, signed_i, dividend_i, divisor_i, flush_i, out_ready_i,
      output in_ready_o, out_valid_o, quotient_o, remainder_o, div_zero_o
   );
endinterface

// File: rtl/r_div_seq.sv
// Iterative restoring DIV/REM unit that handles signed or unsigned operands and returns quotient and remainder.
// Latency: N_ITER+1 cycles from accept to out_valid_o, or 1 cycle for a zero divisor.
// Backpressure: accepts only in IDLE. The result is held in DONE until out_ready_i is seen, and flush_i aborts in any state.
//
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset
//   io       r_div_seq_if.slave, which carries:
//              in_valid_i / in_ready_o    request handshake
//              signed_i                   two's-complement operands when set
//              dividend_i, divisor_i      operands, sampled only on the accept cycle
//              flush_i                    abort and return to IDLE
//              out_valid_o / out_ready_i  result handshake
//              quotient_o, remainder_o    results, valid with out_valid_o
//              div_zero_o                 result came from a zero divisor
//
// BITS_PER_CYCLE must be a power of two and must divide WIDTH.
module r_div_seq #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   r_div_seq_if.slave io
);

   localparam int N_ITER = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // The dividend magnitude and the quotient share one shift register.
   // Dividend bits leave at the top and quotient bits enter at the bottom,
   // so after N_ITER cycles the register holds only the quotient.
   logic [WIDTH-1:0] qd_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] raw_q;      // unmodified dividend, returned as the remainder on divide-by-zero
   logic             neg_q_q;
   logic             neg_r_q;
   logic             dz_q;
   logic [CNT_W-1:0] cnt_q;

   logic             accept;
   logic             last_iter;
   logic             dvd_neg;
   logic             dvs_neg;
   logic [WIDTH-1:0] dvd_mag;
   logic [WIDTH-1:0] dvs_mag;

   logic [WIDTH-1:0] qd_step;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH:0]   sh;
   logic [WIDTH:0]   diff;

   // ---------------------------------------------------------------
   // Operand conditioning
   // ---------------------------------------------------------------
   // A flush in the same cycle as a request discards the request.
   assign accept    = io.in_valid_i & (state_q == IDLE) & ~io.flush_i;
   assign last_iter = (cnt_q == CNT_W'(N_ITER - 1));

   assign dvd_neg = io.signed_i & io.dividend_i[WIDTH-1];
   assign dvs_neg = io.signed_i & io.divisor_i[WIDTH-1];
   // Negating MIN gives MIN again. Read as unsigned, that value is the
   // correct magnitude 2^(WIDTH-1), so MIN / -1 needs no special case.
   assign dvd_mag = dvd_neg ? -io.dividend_i : io.dividend_i;
   assign dvs_mag = dvs_neg ? -io.divisor_i  : io.divisor_i;

   // ---------------------------------------------------------------
   // Restoring cell chain: BITS_PER_CYCLE cells, evaluated MSB-first
   // ---------------------------------------------------------------
   // The partial remainder is always below the divisor, so the shifted
   // value is below 2*divisor. The WIDTH+1-bit difference therefore fits,
   // and its top bit is a reliable borrow flag.
   always_comb begin
      qd_step  = qd_q;
      rem_step = rem_q;
      sh       = '0;
      diff     = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         sh   = {rem_step, qd_step[WIDTH-1]};
         diff = sh - {1'b0, dvs_q};
         if (diff[WIDTH]) begin
            rem_step = sh[WIDTH-1:0];           // borrow: restore the remainder
         end else begin
            rem_step = diff[WIDTH-1:0];
         end
         qd_step = {qd_step[WIDTH-2:0], ~diff[WIDTH]};
      end
   end

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // Next state and outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_d        = state_q;
      io.in_ready_o  = 1'b0;
      io.out_valid_o = 1'b0;
      io.quotient_o  = '0;
      io.remainder_o = '0;
      io.div_zero_o  = 1'b0;

      if (io.flush_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (io.in_valid_i) begin
                  state_d = (io.divisor_i == '0) ? DONE : CALC;
               end
            end
            CALC: begin
               if (last_iter) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (io.out_ready_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      io.in_ready_o = (state_q == IDLE);

      // The sign fixup is combinational from the registered magnitudes.
      // The outputs are gated to DONE so that partial CALC state never
      // reaches the result bus.
      if (state_q == DONE) begin
         io.out_valid_o = 1'b1;
         if (dz_q) begin
            io.quotient_o  = '1;
            io.remainder_o = raw_q;
            io.div_zero_o  = 1'b1;
         end else begin
            io.quotient_o  = neg_q_q ? -qd_q  : qd_q;
            io.remainder_o = neg_r_q ? -rem_q : rem_q;
         end
      end
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         qd_q    <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         raw_q   <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         qd_q    <= dvd_mag;
         rem_q   <= '0;
         dvs_q   <= dvs_mag;
         raw_q   <= io.dividend_i;
         neg_q_q <= io.signed_i & (io.dividend_i[WIDTH-1] ^ io.divisor_i[WIDTH-1]);
         neg_r_q <= dvd_neg;
         dz_q    <= (io.divisor_i == '0);
         cnt_q   <= '0;
      end else if ((state_q == CALC) && !io.flush_i) begin
         qd_q    <= qd_step;
         rem_q   <= rem_step;
         cnt_q   <= cnt_q + 1'b1;
      end
   end

endmodule
